// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    // Access size encodings on req_size; 2'd3 is illegal and always faults.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD_MERGE,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // A request faults when its size is illegal or its address is not
    // naturally aligned for that size. Bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: extract/extend for loads and
// read-modify-write merge for sub-word stores. Lanes are little-endian.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the memory word and extend it.
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        load_val = word;
        case (size)
            SZ_BYTE: load_val = is_unsigned ? {24'd0, byte_sel}
                                            : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = is_unsigned ? {16'd0, half_sel}
                                            : {{16{half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
    end

    // Overwrite only the addressed lane of the old word with store data.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            SZ_WORD: merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: initiator for the word-addressed data memory.
// One request at a time; sub-word stores do a read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic [31:0]       merge_q, merge_d;

    logic              req_fault;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign word_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

    lsu_lane u_lane (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .word        (mem_rd),
        .wdata       (wdata_q),
        .load_val    (load_val),
        .merged      (merged)
    );

    // Next-state, latched request fields and memory/handshake outputs.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        merge_d    = merge_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        req_fault  = is_misaligned(req_size, req_addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Stores and faults respond with zero data; loads
                    // overwrite this in the LOAD cycle.
                    rdata_d = '0;
                    mis_d   = req_fault;
                    // Word stores skip the read; the buffer is the data.
                    merge_d = req_wdata;
                    if (req_fault)               state_d = ST_RESP;
                    else if (!req_we)            state_d = ST_LOAD;
                    else if (req_size == SZ_WORD) state_d = ST_WRITE;
                    else                         state_d = ST_RD_MERGE;
                end
            end
            ST_LOAD: begin
                mem_a   = word_addr;
                rdata_d = load_val;
                state_d = ST_RESP;
            end
            ST_RD_MERGE: begin
                mem_a   = word_addr;
                merge_d = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_a   = word_addr;
                // Gated by reset so a WRITE cycle under reset leaves memory alone.
                mem_we  = rst_n;
                mem_wd  = merge_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            merge_q <= merge_d;
        end
    end

    // Latched request fields; only meaningful while a request is in flight.
    always_ff @(posedge clk) begin
        size_q  <= size_d;
        uns_q   <= uns_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

endmodule
